// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared constants for the data memory / MMIO block: MMIO register
// addresses, STATUS bit positions and an address-region decoder.
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam logic [31:0] ADDR_OUT_DATA = 32'h0000_FF00;
    localparam logic [31:0] ADDR_STATUS   = 32'h0000_FF04;
    localparam logic [31:0] ADDR_CYCLE    = 32'h0000_FF08;

    // STATUS read value = {29'b0, ovf, full, empty}
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;

    typedef enum logic [2:0] {
        RegNone,
        RegRam,
        RegOut,
        RegStatus,
        RegCycle
    } region_e;

    // Byte offset bits are ignored for decode; alignment is checked separately.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr < ram_bytes)              return RegRam;
        else if (word_addr == ADDR_OUT_DATA)    return RegOut;
        else if (word_addr == ADDR_STATUS)      return RegStatus;
        else if (word_addr == ADDR_CYCLE)       return RegCycle;
        else                                    return RegNone;
    endfunction

endpackage

// File: rtl/out_fifo.sv
// ---------------------------------------------------------------------------
// out_fifo
// Synchronous FIFO for the MMIO output port. A push while full is accepted
// only when a pop happens in the same cycle.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-low; empties the FIFO
//   i_push   - push request (i_data)
//   i_pop    - pop request (ignored while empty)
//   i_data   - push data
//   o_head   - current head word (undefined content while empty)
//   o_full   - FIFO holds DEPTH entries
//   o_empty  - FIFO holds no entries
// ---------------------------------------------------------------------------
module out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/data_mem_mmio.sv
// ---------------------------------------------------------------------------
// data_mem_mmio
// Data memory for a single-cycle MIPS core: word RAM plus three MMIO
// registers (output FIFO, STATUS, free-running CYCLE counter).
// Ports:
//   clk             - clock, rising edge
//   reset           - synchronous, active-low
//   dmem_write      - store strobe
//   addr            - byte address (core alu_out)
//   dmem_write_data - store data
//   dmem_read_data  - combinational load data
//   out_valid       - output FIFO head valid
//   out_data        - output FIFO head word (0 when empty)
//   out_ready       - consumer accepts head
//   err             - sticky misaligned-store flag
// ---------------------------------------------------------------------------
module data_mem_mmio
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] addr,
    input  logic [31:0] dmem_write_data,
    output logic [31:0] dmem_read_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        err
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0] r_ram [MEM_WORDS];
    logic [31:0] r_cycle;
    logic        r_ovf;
    logic        r_err;

    region_e     w_region;
    logic        w_aligned;
    logic        w_store_ok;
    logic        w_misaligned;
    logic        w_ram_we;
    logic        w_push_req;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_stat_wr;
    logic        w_cyc_wr;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_head;
    logic [31:0] w_status;

    assign w_region     = decode_region(addr, RAM_BYTES);
    assign w_aligned    = (addr[1:0] == 2'b00);
    // Stores are dropped entirely while reset is asserted.
    assign w_store_ok   = dmem_write & w_aligned & reset;
    assign w_misaligned = dmem_write & ~w_aligned & reset;

    assign w_ram_we   = w_store_ok & (w_region == RegRam);
    assign w_push_req = w_store_ok & (w_region == RegOut);
    assign w_stat_wr  = w_store_ok & (w_region == RegStatus);
    assign w_cyc_wr   = w_store_ok & (w_region == RegCycle);

    assign w_pop      = out_valid & out_ready & reset;
    // A push into a full FIFO survives only if the head leaves this cycle.
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (dmem_write_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? 32'h0 : w_head;
    assign err       = r_err;

    always_comb begin
        w_status                 = 32'h0;
        w_status[STAT_EMPTY_BIT] = w_empty;
        w_status[STAT_FULL_BIT]  = w_full;
        w_status[STAT_OVF_BIT]   = r_ovf;
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[addr[AW+1:2]] <= dmem_write_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle <= 32'h0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cycle <= w_cyc_wr ? 32'h0 : r_cycle + 32'h1;
            if (w_stat_wr) begin
                r_ovf <= 1'b0;
                r_err <= 1'b0;
            end else begin
                if (w_ovf_set)    r_ovf <= 1'b1;
                if (w_misaligned) r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        dmem_read_data = 32'h0;
        case (w_region)
            RegRam:    dmem_read_data = r_ram[addr[AW+1:2]];
            RegOut:    dmem_read_data = out_data;
            RegStatus: dmem_read_data = w_status;
            RegCycle:  dmem_read_data = r_cycle;
            default:   dmem_read_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// ---------------------------------------------------------------------------
// tb_data_mem_mmio
// Directed bench for data_mem_mmio. FIFO expectations come from a queue that
// is filled as stores are driven and drained as the head is consumed; STATUS
// expectations are derived from that queue plus a modelled ovf bit.
// ---------------------------------------------------------------------------
module tb_data_mem_mmio;

    localparam int unsigned DEPTH       = 4;
    localparam logic [31:0] A_OUT       = 32'h0000_FF00;
    localparam logic [31:0] A_STATUS    = 32'h0000_FF04;
    localparam logic [31:0] A_CYCLE     = 32'h0000_FF08;

    logic        clk;
    logic        reset;
    logic        dmem_write;
    logic [31:0] addr;
    logic [31:0] dmem_write_data;
    logic [31:0] dmem_read_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] exp_q [$];
    logic        m_ovf;
    logic [31:0] rd;

    data_mem_mmio #(
        .MEM_WORDS  (64),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_write      (dmem_write),
        .addr            (addr),
        .dmem_write_data (dmem_write_data),
        .dmem_read_data  (dmem_read_data),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dmem_read_data;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dmem_write      = 1'b1;
        addr            = a;
        dmem_write_data = d;
        tick();
        dmem_write      = 1'b0;
    endtask

    function automatic logic [31:0] status_exp();
        return {29'b0, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
    endfunction

    // Store to OUT_DATA, updating the model for any pop in the same cycle.
    task automatic push_word(input logic [31:0] d);
        if (out_ready && exp_q.size() > 0) begin
            check("pop_with_push", out_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else                      m_ovf = 1'b1;
        store(A_OUT, d);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) begin
            check("drain_valid", {31'b0, out_valid}, 32'h1);
            check("drain_data", out_data, exp_q[0]);
            void'(exp_q.pop_front());
            tick();
        end
        check("drain_empty_valid", {31'b0, out_valid}, 32'h0);
        check("drain_empty_data", out_data, 32'h0);
    endtask

    initial begin
        reset           = 1'b0;
        dmem_write      = 1'b0;
        addr            = 32'h0;
        dmem_write_data = 32'h0;
        out_ready       = 1'b0;
        m_ovf           = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        load(A_STATUS, rd); check("rst_status", rd, 32'h1);
        load(A_CYCLE, rd);  check("rst_cycle", rd, 32'h0);
        reset = 1'b1;

        // RAM store then load, byte offset ignored on reads
        store(32'h10, 32'hDEAD_BEEF);
        load(32'h10, rd); check("ram_rd_10", rd, 32'hDEAD_BEEF);
        load(32'h13, rd); check("ram_rd_13", rd, 32'hDEAD_BEEF);
        store(32'hFC, 32'h0BAD_F00D);
        load(32'hFC, rd); check("ram_rd_top", rd, 32'h0BAD_F00D);

        // Unmapped accesses
        load(32'h0000_8000, rd); check("unmapped_rd", rd, 32'h0);
        store(32'h0000_9000, 32'h5);
        check("unmapped_st_err", {31'b0, err}, 32'h0);
        load(32'h0000_FF0C, rd); check("unmapped_rd_ff0c", rd, 32'h0);

        // Overflow: five pushes into a four-entry FIFO with no consumer
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(32'(i));
        load(A_STATUS, rd); check("ovf_status", rd, status_exp());
        check("ovf_status_abs", rd, 32'h6);
        load(A_OUT, rd); check("out_load_head", rd, 32'h1);
        load(A_OUT, rd); check("out_load_no_pop", rd, 32'h1);
        drain();
        load(A_STATUS, rd); check("post_drain_status", rd, 32'h5);
        store(A_STATUS, 32'h0);
        m_ovf = 1'b0;
        load(A_STATUS, rd); check("status_clear", rd, status_exp());

        // Push and pop together while full: no overflow, order preserved
        out_ready = 1'b0;
        for (int i = 11; i <= 14; i++) push_word(32'(i));
        load(A_STATUS, rd); check("full_status", rd, 32'h2);
        out_ready = 1'b1;
        push_word(32'h9);
        out_ready = 1'b0;
        load(A_STATUS, rd); check("full_pushpop_status", rd, status_exp());
        check("full_pushpop_abs", rd, 32'h2);
        drain();
        load(A_STATUS, rd); check("after_pp_status", rd, 32'h1);

        // CYCLE counter
        store(A_CYCLE, 32'h1234);
        repeat (10) tick();
        load(A_CYCLE, rd); check("cycle_10", rd, 32'd10);
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle;
        load(A_CYCLE, rd); check("cycle_forced", rd, 32'hFFFF_FFFF);
        tick();
        load(A_CYCLE, rd); check("cycle_wrap", rd, 32'h0);

        // Misaligned store, with ovf also set; STATUS store clears both
        store(32'h20, 32'h0000_1234);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'h100 + 32'(i));
        store(32'h21, 32'hFFFF_FFFF);
        check("misaligned_err", {31'b0, err}, 32'h1);
        load(32'h20, rd); check("misaligned_ram", rd, 32'h0000_1234);
        load(A_STATUS, rd); check("misaligned_status", rd, status_exp());
        store(A_STATUS, 32'h0);
        m_ovf = 1'b0;
        check("status_clr_err", {31'b0, err}, 32'h0);
        load(A_STATUS, rd); check("status_clr_ovf", rd, 32'h2);
        drain();

        // Reset mid-operation drops FIFO contents and any store in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(32'h200 + 32'(i));
        check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        reset = 1'b0;
        store(32'h20, 32'h0000_AAAA);
        exp_q.delete();
        m_ovf = 1'b0;
        check("midrst_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_data", out_data, 32'h0);
        load(A_STATUS, rd); check("midrst_status", rd, 32'h1);
        load(A_CYCLE, rd);  check("midrst_cycle", rd, 32'h0);
        load(32'h20, rd);   check("midrst_ram_kept", rd, 32'h0000_1234);
        reset = 1'b1;

        // FIFO usable again after reset
        push_word(32'h77);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
